dds_nco: RTL and testbench
==========================

Name: dds_nco

Overview:
- Parametrised phase-accumulator NCO; successor to the fixed 8-entry counter-based sine DDS.
- Generates one signed sample per enabled clock from a tuning word (FCW) and a phase offset (POW).
- Selectable waveform: sine, square, triangle or saw.
- Sits between the control register block and the DAC/mixer path.
- Config updates are double-buffered and take effect on a sample boundary.

Parameters:
PHASE_W, 24, accumulator/FCW/POW width (must be >= OUT_W+1 and > LUT_AW)
LUT_AW, 8, sine table address width (2^LUT_AW entries, full wave)
OUT_W, 16, signed output sample width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  sample strobe; each high cycle takes one sample and advances phase
fcw_in  in  PHASE_W  frequency control word, unsigned
pow_in  in  PHASE_W  phase offset word, unsigned
wave_sel  in  2  0 sine, 1 square, 2 triangle, 3 saw
cfg_load  in  1  capture fcw_in/pow_in/wave_sel into the shadow registers
sync_clr  in  1  zero the phase accumulator
out  out  OUT_W  signed sample
out_valid  out  1  out holds a new sample this cycle

Behaviour:
- Reset: clears acc, active/shadow fcw, pow and wave, pending flag, pipeline registers, out and out_valid (all 0).
- Clock and reset are fixed: one clock, clk; reset rst is synchronous and active-high.
- Priority: rst > sync_clr > accumulate.
- Shadow config:
  - cfg_load=1 captures inputs into the shadow registers and sets pending.
  - A repeat cfg_load while pending overwrites the shadow; pending stays set.
  - On the first en edge strictly after the load edge with pending=1: active <= shadow, pending <= 0.
  - The sample taken at that edge already uses the new fcw, pow and wave.
- Accumulate:
  - On an en edge: acc <= acc + fcw (mod 2^PHASE_W).
  - The sample at that edge uses the pre-increment acc, so the first sample after reset is phase 0.
  - With en=0, acc holds.
- sync_clr: acc <= 0 on that edge. If en=1 on the same edge, the sample still uses the old acc.
- Pipeline:
  - Stage 1 (en edge): ph = acc + pow (mod 2^PHASE_W); register ph and wave.
  - Stage 2: register out from the waveform function.
  - Latency: 2 clocks. out_valid = en delayed 2 clocks; out holds its value when out_valid=0.
- Waveforms, with MAX = 2^(OUT_W-1)-1 and p = ph:
  - sine: LUT[p top LUT_AW bits]. Entry k = round(MAX*sin(2πk/2^LUT_AW)), clamped to ±MAX (never -2^(OUT_W-1)).
  - square: +MAX when p msb = 0, else -MAX.
  - saw: top OUT_W bits of p with msb inverted, read as signed. Runs -2^(OUT_W-1) to MAX.
  - triangle: b = p[PHASE_W-2 -: OUT_W]; t = msb ? ~b : b; out = t with msb inverted.
- Arithmetic is unsigned modulo on phase. No saturation is needed elsewhere.
- Output frequency: f_out = fcw * f_en / 2^PHASE_W.

Optional Feature:
- Macro: DDS_PHASE_DITHER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on rst) advances on each en edge.
  - Its low D = min(16, PHASE_W-LUT_AW) bits are added to ph below the LUT address, before truncation.
  - Affects sine only.
- Undefined: plain truncation; no LFSR logic is present.

Decomposition:
- Package dds_pkg:
  - wave_e enum: WAVE_SINE, WAVE_SQUARE, WAVE_TRI, WAVE_SAW.
  - LFSR seed/taps constants.
  - Function computing MAX from OUT_W.
- Sub-module dds_sine_lut (LUT_AW, OUT_W): combinational ROM built at elaboration from the rounding rule, clamped.

Test Plan (default parameters):
- rst; fcw=0x100000, pow=0, sine; cfg_load; en=1 continuous -> out_valid rises 2 clocks after the first en edge; samples 0,4,8,12 = 0, 32767, 0, -32767; period 16.
- Same fcw, wave=square, then saw, then triangle:
  - square: samples 0-7 = 32767, 8-15 = -32767.
  - saw: sample0 = -32768, sample8 = 0.
  - triangle: sample0 = -32768, sample8 = 32767 region peak.
- fcw=0, pow=0x400000, sine -> constant 32767. Then fcw=0xFFFFFF -> phase decrements by 1 per sample; wrap through 0 with no glitch.
- Mid-stream cfg_load (fcw 0x100000→0x200000) with en=0 for 3 cycles -> no out change until the next en. The first en sample uses the new config; period becomes 8.
- sync_clr together with en at acc=0x500000 -> that sample from 0x500000; the next sample from phase 0.
- rst asserted mid-run -> next cycle out=0, out_valid=0, pending=0; after release with no cfg_load and en=1 -> out stays 0 (fcw=0, sine).

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types and constants for the phase-accumulator NCO.
// Optional build macro: DDS_PHASE_DITHER_EN (LFSR phase dither on the sine path).
package dds_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_e;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Largest positive sample; the negative full-scale code is never produced by sine/square
  function automatic int max_amp(input int out_w);
    return (1 << (out_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/dds_sine_lut.sv
// Full-wave sine ROM, filled at elaboration with round(MAX*sin), clamped to +/-MAX.
module dds_sine_lut
  import dds_pkg::*;
#(
  parameter int LUT_AW = 8,
  parameter int OUT_W  = 16
) (
  input  logic [LUT_AW-1:0]       addr,
  output logic signed [OUT_W-1:0] data
);

  localparam int N   = 1 << LUT_AW;
  localparam int MAX = max_amp(OUT_W);

  function automatic logic [OUT_W-1:0] entry(input int k);
    real r;
    int  v;
    r = real'(MAX) * $sin(2.0 * 3.14159265358979 * real'(k) / real'(N));
    v = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    if (v > MAX)  v = MAX;
    if (v < -MAX) v = -MAX;
    return OUT_W'(v);
  endfunction

  logic [OUT_W-1:0] rom [N];

  // One constant per table entry
  for (genvar k = 0; k < N; k++) begin : g_rom
    assign rom[k] = entry(k);
  end

  assign data = signed'(rom[addr]);

endmodule

// File: rtl/dds_nco.sv
// Phase-accumulator NCO: double-buffered config, 2-clock pipeline,
// sine/square/triangle/saw. Optional macro DDS_PHASE_DITHER_EN adds LFSR
// dither below the sine table address.
module dds_nco
  import dds_pkg::*;
#(
  parameter int PHASE_W = 24,
  parameter int LUT_AW  = 8,
  parameter int OUT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [PHASE_W-1:0]      fcw_in,
  input  logic [PHASE_W-1:0]      pow_in,
  input  logic [1:0]              wave_sel,
  input  logic                    cfg_load,
  input  logic                    sync_clr,
  output logic signed [OUT_W-1:0] out,
  output logic                    out_valid
);

  localparam int LAT = 2;
  localparam logic signed [OUT_W-1:0] MAX = OUT_W'(max_amp(OUT_W));

  typedef struct packed {
    logic [PHASE_W-1:0] fcw;
    logic [PHASE_W-1:0] pow;
    wave_e              wave;
  } cfg_t;

  cfg_t                    cfg_act, cfg_sh, cfg_eff;
  logic                    pending;
  logic [PHASE_W-1:0]      acc, ph_next;
  logic [OUT_W:0]          ph_top;   // phase bits the non-sine shapes need
  logic [LUT_AW-1:0]       lut_addr;
  wave_e                   wave_p;
  logic [LAT-1:0]          vld_pipe;
  logic signed [OUT_W-1:0] lut_data, wave_out;
  logic [OUT_W-1:0]        tri_t;

  // A pending shadow is consumed by the first en edge and already drives that sample
  always_comb begin
    cfg_eff = cfg_act;
    if (en && pending) cfg_eff = cfg_sh;
  end

  assign ph_next = acc + cfg_eff.pow;

  // Shadow capture and hand-over to the active set
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_act <= cfg_t'('0);
      cfg_sh  <= cfg_t'('0);
      pending <= 1'b0;
    end else begin
      if (en && pending) cfg_act <= cfg_sh;
      if (cfg_load) begin
        cfg_sh  <= '{fcw: fcw_in, pow: pow_in, wave: wave_e'(wave_sel)};
        pending <= 1'b1;
      end else if (en) begin
        pending <= 1'b0;
      end
    end
  end

  // Phase accumulator; the sample on this edge sees the pre-increment value
  always_ff @(posedge clk) begin
    if (rst)           acc <= '0;
    else if (sync_clr) acc <= '0;
    else if (en)       acc <= acc + cfg_eff.fcw;
  end

`ifdef DDS_PHASE_DITHER_EN
  localparam int D = (PHASE_W - LUT_AW < 16) ? (PHASE_W - LUT_AW) : 16;
  logic [15:0] lfsr;

  // Dither source steps once per sample
  always_ff @(posedge clk) begin
    if (rst)     lfsr <= LFSR_SEED;
    else if (en) lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end
`endif

  // Stage 1: offset phase, table address and waveform select
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_top   <= '0;
      lut_addr <= '0;
      wave_p   <= WAVE_SINE;
    end else if (en) begin
      ph_top   <= ph_next[PHASE_W-1 -: OUT_W+1];
`ifdef DDS_PHASE_DITHER_EN
      lut_addr <= LUT_AW'((ph_next + PHASE_W'(lfsr[D-1:0])) >> (PHASE_W - LUT_AW));
`else
      lut_addr <= ph_next[PHASE_W-1 -: LUT_AW];
`endif
      wave_p   <= cfg_eff.wave;
    end
  end

  dds_sine_lut #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_lut (
    .addr (lut_addr),
    .data (lut_data)
  );

  // Waveform shaping from the registered phase
  always_comb begin
    tri_t    = ph_top[OUT_W] ? ~ph_top[OUT_W-1:0] : ph_top[OUT_W-1:0];
    wave_out = lut_data;
    unique case (wave_p)
      WAVE_SINE:   wave_out = lut_data;
      WAVE_SQUARE: wave_out = ph_top[OUT_W] ? -MAX : MAX;
      WAVE_TRI:    wave_out = signed'({~tri_t[OUT_W-1], tri_t[OUT_W-2:0]});
      WAVE_SAW:    wave_out = signed'({~ph_top[OUT_W], ph_top[OUT_W-1:1]});
      default:     wave_out = lut_data;
    endcase
  end

  // Stage 2 output register plus matching valid shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      out      <= '0;
      vld_pipe <= '0;
    end else begin
      if (vld_pipe[0]) out <= wave_out;
      vld_pipe <= {vld_pipe[LAT-2:0], en};
    end
  end

  assign out_valid = vld_pipe[LAT-1];

endmodule

// File: tb/tb_dds_nco.sv
// Scoreboard bench for dds_nco: a phase/config model pushes expected samples,
// a negedge monitor pops them whenever out_valid is high.
module tb_dds_nco;

  localparam int PW = 24;
  localparam int AW = 8;
  localparam int OW = 16;
  localparam int unsigned MASK = (1 << PW) - 1;
  localparam int AMAX = (1 << (OW - 1)) - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en = 1'b0;
  logic                 cfg_load = 1'b0;
  logic                 sync_clr = 1'b0;
  logic [PW-1:0]        fcw_in = '0;
  logic [PW-1:0]        pow_in = '0;
  logic [1:0]           wave_sel = '0;
  logic signed [OW-1:0] out;
  logic                 out_valid;

  dds_nco #(.PHASE_W(PW), .LUT_AW(AW), .OUT_W(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fcw_in    (fcw_in),
    .pow_in    (pow_in),
    .wave_sel  (wave_sel),
    .cfg_load  (cfg_load),
    .sync_clr  (sync_clr),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int val; int cyc; } exp_t;
  exp_t q[$];

  int checks = 0, errors = 0, cyc = 0, exp_last = 0;
  bit mon_on = 1'b0;

  // reference state
  int unsigned m_acc = 0, a_fcw = 0, a_pow = 0, s_fcw = 0, s_pow = 0;
  int          a_wave = 0, s_wave = 0;
  bit          m_pend = 1'b0;

  // Ideal sample for phase p, straight from the waveform definitions
  function automatic int ref_sample(input int unsigned p, input int w);
    real r;
    int v;
    int unsigned k, b, t;
    case (w)
      0: begin
        k = p >> (PW - AW);
        r = real'(AMAX) * $sin(2.0 * 3.14159265358979 * real'(k) / real'(1 << AW));
        v = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
        if (v > AMAX)  v = AMAX;
        if (v < -AMAX) v = -AMAX;
        return v;
      end
      1: return (p < (1 << (PW - 1))) ? AMAX : -AMAX;
      2: begin
        b = (p >> (PW - 1 - OW)) & ((1 << OW) - 1);
        t = (p < (1 << (PW - 1))) ? b : ((1 << OW) - 1) - b;
        return int'(t) - (1 << (OW - 1));
      end
      default: return int'(p >> (PW - OW)) - (1 << (OW - 1));
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one clock of inputs, then advance the model by that edge
  task automatic step(input bit r, input bit e, input bit sc, input bit cl,
                      input int unsigned f, input int unsigned p, input int w);
    bit use_new;
    int unsigned fe, pe;
    int we;
    rst = r; en = e; sync_clr = sc; cfg_load = cl;
    fcw_in = PW'(f); pow_in = PW'(p); wave_sel = 2'(w);
    @(posedge clk);
    cyc++;
    if (r) begin
      m_acc = 0; a_fcw = 0; a_pow = 0; a_wave = 0;
      s_fcw = 0; s_pow = 0; s_wave = 0; m_pend = 1'b0;
      q.delete();
      exp_last = 0;
    end else begin
      use_new = e && m_pend;
      fe = use_new ? s_fcw  : a_fcw;
      pe = use_new ? s_pow  : a_pow;
      we = use_new ? s_wave : a_wave;
      if (e) q.push_back('{ref_sample((m_acc + pe) & MASK, we), cyc});
      if (sc)     m_acc = 0;
      else if (e) m_acc = (m_acc + fe) & MASK;
      if (use_new) begin a_fcw = s_fcw; a_pow = s_pow; a_wave = s_wave; end
      if (cl) begin
        s_fcw = f & MASK; s_pow = p & MASK; s_wave = w & 3; m_pend = 1'b1;
      end else if (e) begin
        m_pend = 1'b0;
      end
    end
    #1;
  endtask

  task automatic run_en(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0);
  endtask

  // Monitor: consume a sample on every valid cycle, otherwise out must hold
  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: got out=%0d with no sample expected (cycle %0d)", out, cyc);
        end else begin
          e = q.pop_front();
          check("sample", int'(out), e.val);
          check("latency", cyc, e.cyc + 1);
          exp_last = e.val;
        end
      end else begin
        check("hold", int'(out), exp_last);
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("rst_out", int'(out), 0);
    check("rst_valid", int'(out_valid), 0);
    mon_on = 1'b1;

    // sine, period 16
    step(0, 0, 0, 1, 24'h100000, 0, 0);
    run_en(32);
    // square, saw, triangle at the same rate (load with en high)
    step(0, 1, 0, 1, 24'h100000, 0, 1); run_en(16);
    step(0, 1, 0, 1, 24'h100000, 0, 3); run_en(16);
    step(0, 1, 0, 1, 24'h100000, 0, 2); run_en(16);
    // constant phase via offset, then decrement through the wrap
    step(0, 1, 1, 1, 0, 24'h400000, 0); run_en(8);
    step(0, 1, 0, 1, 24'hFFFFFF, 24'h400000, 0); run_en(20);
    // mid-stream reload while idle
    step(0, 1, 0, 1, 24'h100000, 0, 0); run_en(8);
    step(0, 0, 0, 1, 24'h200000, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    run_en(16);
    // sync_clr alongside en at acc = 0x500000
    step(0, 1, 1, 1, 24'h100000, 0, 0); run_en(5);
    step(0, 1, 1, 0, 0, 0, 0); run_en(4);
    // reset mid-run with a pending load
    step(0, 1, 0, 1, 24'h123456, 24'h11, 1);
    step(1, 1, 0, 0, 0, 0, 0);
    check("midrst_out", int'(out), 0);
    check("midrst_valid", int'(out_valid), 0);
    run_en(10);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit r, e, sc, cl;
      int unsigned f, p;
      r  = ($urandom_range(0, 199) == 0);
      e  = ($urandom_range(0, 99) < 70);
      sc = ($urandom_range(0, 99) < 4);
      cl = ($urandom_range(0, 99) < 10);
      f  = ($urandom_range(0, 1) == 1) ? $urandom() : $urandom_range(0, 24'h0FFFFF);
      p  = $urandom();
      step(r, e, sc, cl, f, p, $urandom_range(0, 3));
    end

    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);
    check("drain", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
